// File: rtl/down_counter_pkg.sv
// Shared constants for the down_counter timebase block.
package down_counter_pkg;
   localparam int DC_DEFAULT_WIDTH = 2;
endpackage

// File: rtl/down_counter_if.sv
// Output bundle of the down counter: count value, terminal count, wrap pulse.
interface down_counter_if
   import down_counter_pkg::*;
#(
   parameter int WIDTH = DC_DEFAULT_WIDTH
) ();
   logic [WIDTH-1:0] count_out;
   logic             tc;
   logic             wrap;

   modport master (output count_out, output tc, output wrap);
   modport slave  (input  count_out, input  tc, input  wrap);
endinterface

// File: rtl/down_counter.sv
// Free-running WIDTH-bit down counter with terminal-count flag and a registered
// one-cycle pulse on each 0 -> all-ones wrap.
module down_counter
   import down_counter_pkg::*;
#(
   parameter int               WIDTH     = DC_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
   input  logic           clk,
   input  logic           reset,
   down_counter_if.master cnt_if
);
   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;

   // Truncating subtraction makes 0 - 1 land on all-ones with no special case.
   always_comb begin
      count_d = count_q - ONE;
      wrap_d  = (count_q == ZERO);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= RESET_VAL;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign cnt_if.count_out = count_q;
   assign cnt_if.tc        = (count_q == ZERO);
   assign cnt_if.wrap      = wrap_q;
endmodule

// File: tb/tb_down_counter.sv
// Bench for down_counter: default 2-bit instance and a 4-bit instance with
// RESET_VAL=5, both checked every cycle against a modular-arithmetic model.
module tb_down_counter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;

   // Reference state: plain integers, period = 2**W
   int   m_cnt_a, m_wrap_a, m_cnt_b, m_wrap_b;

   always #5 clk = ~clk;

   down_counter_if #(.WIDTH(2)) bus_a ();
   down_counter_if #(.WIDTH(4)) bus_b ();

   down_counter #(.WIDTH(2)) dut_a (
      .clk    (clk),
      .reset  (reset),
      .cnt_if (bus_a.master)
   );

   down_counter #(.WIDTH(4), .RESET_VAL(4'd5)) dut_b (
      .clk    (clk),
      .reset  (reset),
      .cnt_if (bus_b.master)
   );

   task automatic chk(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, observed, expected, $time);
      end
   endtask

   // Drive reset level r for the next edge; optional glitch low between edges.
   task automatic step(input logic r, input bit glitch);
      reset = r;
      if (glitch && r) begin
         #2 reset = 1'b0;
         #2 reset = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!r) begin
         m_cnt_a = 3;  m_wrap_a = 0;
         m_cnt_b = 5;  m_wrap_b = 0;
      end else begin
         m_wrap_a = (m_cnt_a == 0) ? 1 : 0;
         m_cnt_a  = (m_cnt_a + 4 - 1) % 4;
         m_wrap_b = (m_cnt_b == 0) ? 1 : 0;
         m_cnt_b  = (m_cnt_b + 16 - 1) % 16;
      end
      chk("a_count", int'(bus_a.count_out), m_cnt_a);
      chk("a_tc",    int'(bus_a.tc),        (m_cnt_a == 0) ? 1 : 0);
      chk("a_wrap",  int'(bus_a.wrap),      m_wrap_a);
      chk("b_count", int'(bus_b.count_out), m_cnt_b);
      chk("b_tc",    int'(bus_b.tc),        (m_cnt_b == 0) ? 1 : 0);
      chk("b_wrap",  int'(bus_b.wrap),      m_wrap_b);
   endtask

   initial begin
      int seq_a[5];
      int seq_b[7];
      int n_tc, n_wrap, last_tc, guard;

      m_cnt_a = 0; m_wrap_a = 0; m_cnt_b = 0; m_wrap_b = 0;
      seq_a = '{3, 2, 1, 0, 3};
      seq_b = '{4, 3, 2, 1, 0, 15, 14};

      // Held reset: fixed values every cycle
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0);
         chk("rst_a_count", int'(bus_a.count_out), 3);
         chk("rst_a_tc",    int'(bus_a.tc),        0);
         chk("rst_a_wrap",  int'(bus_a.wrap),      0);
         chk("rst_b_count", int'(bus_b.count_out), 5);
      end

      // Release: literal sequences from the documented examples
      chk("rel_a_0", int'(bus_a.count_out), seq_a[0]);
      for (int i = 1; i < 7; i++) begin
         step(1'b1, 1'b0);
         if (i < 5) begin
            chk("rel_a_seq",  int'(bus_a.count_out), seq_a[i]);
            chk("rel_a_wrap", int'(bus_a.wrap), (i == 4) ? 1 : 0);
         end
         chk("rel_b_seq",  int'(bus_b.count_out), seq_b[i - 1]);
         chk("rel_b_wrap", int'(bus_b.wrap), (i == 6) ? 1 : 0);
      end

      // Free run: 64 cycles, tc and wrap each 16 times, tc every 4 cycles
      n_tc = 0; n_wrap = 0; last_tc = -1;
      for (int i = 0; i < 64; i++) begin
         step(1'b1, 1'b0);
         if (bus_a.wrap === 1'b1) n_wrap++;
         if (bus_a.tc === 1'b1) begin
            n_tc++;
            if (last_tc >= 0) chk("tc_period", i - last_tc, 4);
            last_tc = i;
         end
      end
      chk("tc_count_64",   n_tc,   16);
      chk("wrap_count_64", n_wrap, 16);

      // Mid-count reset at 01: next value all-ones with no wrap, then resume
      guard = 0;
      while (m_cnt_a != 1 && guard < 8) begin
         step(1'b1, 1'b0);
         guard++;
      end
      chk("mid_at_01", int'(bus_a.count_out), 1);
      step(1'b0, 1'b0);
      chk("mid_rst_val",  int'(bus_a.count_out), 3);
      chk("mid_rst_wrap", int'(bus_a.wrap), 0);
      step(1'b1, 1'b0); chk("mid_resume_10", int'(bus_a.count_out), 2);
      step(1'b1, 1'b0); chk("mid_resume_01", int'(bus_a.count_out), 1);
      step(1'b1, 1'b0); chk("mid_resume_00", int'(bus_a.count_out), 0);

      // Reset landing on the 0 -> all-ones edge suppresses the wrap pulse
      step(1'b0, 1'b0);
      chk("sup_wrap", int'(bus_a.wrap), 0);
      chk("sup_cnt",  int'(bus_a.count_out), 3);

      // Reset glitches between edges must not disturb counting
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1);

      // Randomized reset pattern with occasional glitches
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
